seg7_readback: RTL and testbench

//  Receive side of the 7-segment display bus: samples an externally driven segment pattern
//  (a looped-back animation output or another board's display bus). Synchronizes and

---
 rtl/seg7_readback.sv | 171 +++++++++++++++++
 tb/tb_seg7_readback.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// Receive side of the 7-segment bus: synchronize, deglitch, decode to hex and time pattern changes.
// Define SEG7_RB_ACTIVE_LOW_EN for a common-anode (active-low) segment bus.
module seg7_readback #(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 25,
    parameter int TIMEOUT       = 20_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                change_strb,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                stalled,
    output logic [1:0]          state
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] GAP_MAX  = '1;
    localparam logic [PERIOD_W-1:0] GAP_TO   = PERIOD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_LOCKED  = 2'd2,
        S_STALLED = 2'd3
    } state_t;

    state_t st, st_nxt;

    logic [6:0]          seg_raw;
    logic [6:0]          seg_p0, seg_p1;
    logic [6:0]          cand_p2;
    logic [CNT_W-1:0]    cnt_p2;
    logic [6:0]          acc_p3;
    logic [PERIOD_W-1:0] gap;
    logic [PERIOD_W-1:0] gap_inc;
    logic                cnt_full;
    logic                accept;
    logic                timeout;
    logic                per_upd, pv_set, pv_clr;

    function automatic logic [4:0] decode7(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h07: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

`ifdef SEG7_RB_ACTIVE_LOW_EN
    assign seg_raw = ~seg_in;
`else
    assign seg_raw = seg_in;
`endif

    assign cnt_full = (cnt_p2 == CNT_LAST);
    // Accept only once the candidate has survived the full stability window and differs from the shown glyph.
    assign accept   = (seg_p1 == cand_p2) && cnt_full && (cand_p2 != acc_p3);
    assign timeout  = (gap == GAP_TO);
    assign gap_inc  = (gap == GAP_MAX) ? GAP_MAX : gap + 1'b1;

    // Synchronizer, deglitch window, accepted pattern and gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0      <= '0;
            seg_p1      <= '0;
            cand_p2     <= '0;
            cnt_p2      <= '0;
            acc_p3      <= '0;
            change_strb <= 1'b0;
            gap         <= '0;
        end else begin
            seg_p0 <= seg_raw;
            seg_p1 <= seg_p0;
            if (seg_p1 != cand_p2) begin
                cand_p2 <= seg_p1;
                cnt_p2  <= '0;
            end else if (!cnt_full) begin
                cnt_p2 <= cnt_p2 + 1'b1;
            end
            if (accept)
                acc_p3 <= cand_p2;
            change_strb <= accept;
            if (accept)
                gap <= '0;
            else if (gap != GAP_MAX)
                gap <= gap + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= S_IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        per_upd = 1'b0;
        pv_set  = 1'b0;
        pv_clr  = 1'b0;
        case (st)
            S_IDLE: begin
                if (accept)
                    st_nxt = S_TRACK;
            end
            S_TRACK: begin
                if (accept) begin
                    st_nxt  = S_LOCKED;
                    per_upd = 1'b1;
                    pv_set  = 1'b1;
                end else if (timeout) begin
                    st_nxt = S_STALLED;
                end
            end
            S_LOCKED: begin
                if (accept)
                    per_upd = 1'b1;
                else if (timeout)
                    st_nxt = S_STALLED;
            end
            S_STALLED: begin
                if (accept) begin
                    st_nxt = S_TRACK;
                    pv_clr = 1'b1;
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            if (per_upd)
                period_out <= gap_inc;
            if (pv_set)
                period_valid <= 1'b1;
            else if (pv_clr)
                period_valid <= 1'b0;
        end
    end

    assign {digit_valid, digit} = decode7(acc_p3);
    assign stalled = (st == S_STALLED);
    assign state   = st;

endmodule

// File: tb/tb_seg7_readback.sv
// Self-checking bench for seg7_readback: directed scenarios plus randomized patterns against a window model.
module tb_seg7_readback;

    localparam int STABLE     = 4;
    localparam int PW         = 25;
    localparam int TB_TIMEOUT = 1500;

    logic          clk;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          change_strb;
    logic [PW-1:0] period_out;
    logic          period_valid;
    logic          stalled;
    logic [1:0]    state;

    int checks   = 0;
    int failures = 0;

    seg7_readback #(
        .STABLE_CYCLES(STABLE),
        .PERIOD_W     (PW),
        .TIMEOUT      (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .change_strb (change_strb),
        .period_out  (period_out),
        .period_valid(period_valid),
        .stalled     (stalled),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: a pattern is accepted when the last STABLE+1 synchronized samples agree
    // and differ from the shown one; synchronized sample at edge n is the input before edge n-2.
    logic [6:0] rawq [$];
    logic [6:0] win  [$];
    logic [6:0] m_acc;
    logic       m_strb;
    int         m_state;   // 0 idle, 1 track, 2 locked, 3 stalled
    longint     m_period;
    logic       m_pvalid;
    longint     m_last;
    longint     n;

    function automatic logic [6:0] drv(input logic [6:0] p);
`ifdef SEG7_RB_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return {1'b1, 4'(i)};
        return 5'h00;
    endfunction

    task automatic model_reset();
        rawq = {};
        win  = {};
        rawq.push_back(7'h00);
        rawq.push_back(7'h00);
        for (int i = 0; i < STABLE + 1; i++) win.push_back(7'h00);
        m_acc = 7'h00; m_strb = 1'b0; m_state = 0; m_period = 0;
        m_pvalid = 1'b0; m_last = 0; n = 0;
    endtask

    task automatic step();
        logic [6:0] x, tmp;
        logic       eq;
        rawq.push_back(drv(seg_in));
        x = rawq.pop_front();
        @(posedge clk);
        n++;
        win.push_back(x);
        tmp = win.pop_front();
        eq = 1'b1;
        foreach (win[i]) if (win[i] != win[0]) eq = 1'b0;
        m_strb = eq && (win[0] != m_acc);
        if (m_strb) begin
            if (m_state == 1 || m_state == 2) begin
                m_period = n - m_last;
                if (m_period > longint'({PW{1'b1}})) m_period = longint'({PW{1'b1}});
            end
            case (m_state)
                0: m_state = 1;
                1: begin m_state = 2; m_pvalid = 1'b1; end
                2: m_state = 2;
                default: begin m_state = 1; m_pvalid = 1'b0; end
            endcase
            m_acc  = win[0];
            m_last = n;
        end else if ((m_state == 1 || m_state == 2) && (n - m_last - 1 == TB_TIMEOUT)) begin
            m_state = 3;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        seg_in = drv(7'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({digit, digit_valid, change_strb, period_valid, stalled, state} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0", {digit, digit_valid, change_strb, period_valid, stalled, state});
        end
        checks++;
        if (period_out !== '0) begin
            failures++;
            $display("FAIL reset_period got=%0d want=0", period_out);
        end
    endtask

    task automatic test_first_accept();
        int strobe_edge = -1;
        seg_in = drv(7'h3F);
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (change_strb !== m_strb) begin
                failures++;
                $display("FAIL first_strb edge=%0d got=%b want=%b", i, change_strb, m_strb);
            end
            if (change_strb === 1'b1 && strobe_edge < 0) strobe_edge = i;
        end
        checks++;
        if (strobe_edge != STABLE + 3) begin
            failures++;
            $display("FAIL first_latency got=%0d want=%0d", strobe_edge, STABLE + 3);
        end
        checks++;
        if ({digit_valid, digit, state, period_valid} !== {1'b1, 4'h0, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL first_state got=%b/%h/%0d/%b want=1/0/1/0", digit_valid, digit, state, period_valid);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] pats [3] = '{7'h06, 7'h5B, 7'h4F};
        for (int p = 0; p < 3; p++) begin
            seg_in = drv(pats[p]);
            for (int i = 0; i < 1000; i++) begin
                step();
                checks++;
                if (change_strb !== m_strb) begin
                    failures++;
                    $display("FAIL seq_strb pat=%h got=%b want=%b", pats[p], change_strb, m_strb);
                end
            end
            checks++;
            if (digit !== 4'(p + 1) || digit_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_digit got=%h/%b want=%0d/1", digit, digit_valid, p + 1);
            end
        end
        checks++;
        if (period_out !== PW'(1000) || state !== 2'd2 || period_valid !== 1'b1) begin
            failures++;
            $display("FAIL seq_period got=%0d st=%0d pv=%b want=1000/2/1", period_out, state, period_valid);
        end
    endtask

    task automatic test_glitch();
        int strobes = 0;
        seg_in = drv(7'h7F);
        repeat (3) step();
        seg_in = drv(7'h4F);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            if (change_strb === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0 || digit !== 4'h3) begin
            failures++;
            $display("FAIL glitch_short strobes=%0d digit=%h want=0/3", strobes, digit);
        end
        seg_in = drv(7'h7F);
        for (int i = 0; i < 10; i++) begin
            step();
            if (change_strb === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 1 || digit !== 4'h8) begin
            failures++;
            $display("FAIL glitch_long strobes=%0d digit=%h want=1/8", strobes, digit);
        end
    endtask

    task automatic test_stall();
        logic [PW-1:0] held;
        held = period_out;
        for (int i = 0; i < TB_TIMEOUT + 20; i++) begin
            step();
            checks++;
            if (state !== 2'(m_state) || stalled !== (m_state == 3)) begin
                failures++;
                $display("FAIL stall_fsm cyc=%0d got=%0d/%b want=%0d", i, state, stalled, m_state);
            end
        end
        checks++;
        if (stalled !== 1'b1 || state !== 2'd3 || period_out !== held || period_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold st=%0d stl=%b per=%0d pv=%b want=3/1/%0d/1", state, stalled, period_out, period_valid, held);
        end
        seg_in = drv(7'h06);
        repeat (10) step();
        checks++;
        if (state !== 2'd1 || period_valid !== 1'b0 || period_out !== held || stalled !== 1'b0) begin
            failures++;
            $display("FAIL stall_exit st=%0d pv=%b per=%0d want=1/0/%0d", state, period_valid, period_out, held);
        end
    endtask

    task automatic test_invalid_and_reset();
        int strobes = 0;
        seg_in = drv(7'h49);
        for (int i = 0; i < 10; i++) begin
            step();
            if (change_strb === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 1 || digit_valid !== 1'b0 || digit !== 4'h0) begin
            failures++;
            $display("FAIL invalid strobes=%0d dv=%b digit=%h want=1/0/0", strobes, digit_valid, digit);
        end
        seg_in = drv(7'h5B);
        repeat (10) step();
        seg_in = drv(7'h66);
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({digit, digit_valid, change_strb, period_valid, stalled, state} !== 10'b0 || period_out !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h/%b/%b/%b/%b/%0d per=%0d want=0", digit, digit_valid, change_strb, period_valid, stalled, state, period_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (state !== 2'd1 || digit !== 4'h4 || period_valid !== 1'b0 || period_out !== '0) begin
            failures++;
            $display("FAIL post_reset st=%0d digit=%h pv=%b per=%0d want=1/4/0/0", state, digit, period_valid, period_out);
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        logic [4:0] dec;
        int         hold;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) p = 7'($urandom);
            else p = glyph[$urandom_range(0, 15)];
            seg_in = drv(p);
            hold = $urandom_range(1, 12);
            for (int i = 0; i < hold; i++) begin
                step();
                dec = ref_decode(m_acc);
                checks++;
                if (change_strb !== m_strb || {digit_valid, digit} !== dec || state !== 2'(m_state)
                    || period_valid !== m_pvalid || period_out !== PW'(m_period)) begin
                    failures++;
                    $display("FAIL random k=%0d strb=%b/%b dig=%b%h/%h st=%0d/%0d pv=%b/%b per=%0d/%0d",
                             k, change_strb, m_strb, digit_valid, digit, dec, state, m_state,
                             period_valid, m_pvalid, period_out, m_period);
                end
            end
        end
    endtask

`ifdef SEG7_RB_ACTIVE_LOW_EN
    task automatic test_active_low();
        int strobes = 0;
        apply_reset();
        seg_in = 7'h7F;
        for (int i = 0; i < 20; i++) begin
            step();
            if (change_strb === 1'b1) strobes++;
        end
        checks++;
        if (strobes != 0 || state !== 2'd0) begin
            failures++;
            $display("FAIL al_idle strobes=%0d st=%0d want=0/0", strobes, state);
        end
        seg_in = 7'h40;
        repeat (10) step();
        checks++;
        if (digit !== 4'h0 || digit_valid !== 1'b1 || state !== 2'd1) begin
            failures++;
            $display("FAIL al_zero digit=%h dv=%b st=%0d want=0/1/1", digit, digit_valid, state);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        seg_in = 7'h00;
        model_reset();
        test_reset();
        test_first_accept();
        test_sequence();
        test_glitch();
        test_stall();
        test_invalid_and_reset();
        test_random();
`ifdef SEG7_RB_ACTIVE_LOW_EN
        test_active_low();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
